// File: rtl/key_scan.sv
// key_scan: 4x4 key-matrix scanner with a 2-flop row synchronizer and
// frame-based debounce. It drives one active-low column per SCAN_DIV
// cycles and assembles a 16-bit frame every four columns.
// Optional feature macro: KEY_SCAN_DEBOUNCE_EN. When it is defined, `keys`
// updates only after DEBOUNCE_CNT identical frames. When it is undefined,
// `keys` follows every completed frame and DEBOUNCE_CNT is not used.
module key_scan #(
  parameter int SCAN_DIV     = 16,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic [15:0] keys,
  output logic        key_change
);

  localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

  // Stop elaboration when a parameter is outside its legal range.
  if (SCAN_DIV < 4 || SCAN_DIV > 65535 || DEBOUNCE_CNT < 1 || DEBOUNCE_CNT > 15) begin : g_bad_param
    $error("key_scan: SCAN_DIV or DEBOUNCE_CNT out of range");
  end

  logic [3:0]  sync1_q, sync1_d;
  logic [3:0]  sync2_q, sync2_d;
  logic [15:0] div_q, div_d;
  logic [1:0]  col_q, col_d;
  logic [3:0]  col_out_q, col_out_d;
  logic [15:0] frame_q, frame_d;
  logic [15:0] prev_q, prev_d;
  logic        load_q, load_d;
  logic [15:0] keys_q, keys_d;
  logic        key_change_q, key_change_d;

  logic        tc_s;
  logic        frame_done_s;
  logic [3:0]  pressed_s;
  logic [15:0] spread_s;

`ifdef KEY_SCAN_DEBOUNCE_EN
  localparam logic [3:0] DB_MAX = 4'(DEBOUNCE_CNT);
  logic [3:0]  stab_q, stab_d;
`endif

  // Next-state logic for the synchronizer, scan timing, frame assembly and key update.
  always_comb begin
    sync1_d      = row_in;
    sync2_d      = sync1_q;
    tc_s         = (div_q == DIV_LAST);
    pressed_s    = ~sync2_q;
    // Place row r at bit 4*r; the later shift by col_q moves it to bit 4*r+col.
    spread_s     = {3'b000, pressed_s[3], 3'b000, pressed_s[2],
                    3'b000, pressed_s[1], 3'b000, pressed_s[0]};
    div_d        = div_q;
    col_d        = col_q;
    frame_d      = frame_q;
    prev_d       = prev_q;
    load_d       = 1'b0;
    frame_done_s = 1'b0;

    if (tc_s) begin
      div_d   = 16'd0;
      col_d   = col_q + 2'd1;
      frame_d = (frame_q & ~(16'h1111 << col_q)) | (spread_s << col_q);
      frame_done_s = (col_q == 2'd3);
    end else begin
      div_d   = div_q + 16'd1;
    end

    col_out_d = ~(4'b0001 << col_d);

    if (frame_done_s) begin
      prev_d = frame_d;
    end else begin
      prev_d = prev_q;
    end

`ifdef KEY_SCAN_DEBOUNCE_EN
    stab_d = stab_q;
    if (frame_done_s) begin
      if (frame_d == prev_q) begin
        stab_d = (stab_q == DB_MAX) ? stab_q : stab_q + 4'd1;
      end else begin
        stab_d = 4'd1;
      end
    end else begin
      stab_d = stab_q;
    end
    load_d = frame_done_s && (stab_d == DB_MAX);
`else
    load_d = frame_done_s;
`endif

    // prev_q holds the last completed frame until the next completion.
    if (load_q) begin
      keys_d = prev_q;
    end else begin
      keys_d = keys_q;
    end
    key_change_d = (keys_d != keys_q);
  end

  // State registers with a synchronous reset that abandons any partial frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q      <= 4'b1111;
      sync2_q      <= 4'b1111;
      div_q        <= 16'd0;
      col_q        <= 2'd0;
      col_out_q    <= 4'b1110;
      frame_q      <= 16'h0000;
      prev_q       <= 16'h0000;
      load_q       <= 1'b0;
      keys_q       <= 16'h0000;
      key_change_q <= 1'b0;
`ifdef KEY_SCAN_DEBOUNCE_EN
      stab_q       <= 4'd0;
`endif
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      div_q        <= div_d;
      col_q        <= col_d;
      col_out_q    <= col_out_d;
      frame_q      <= frame_d;
      prev_q       <= prev_d;
      load_q       <= load_d;
      keys_q       <= keys_d;
      key_change_q <= key_change_d;
`ifdef KEY_SCAN_DEBOUNCE_EN
      stab_q       <= stab_d;
`endif
    end
  end

  assign col_out    = col_out_q;
  assign keys       = keys_q;
  assign key_change = key_change_q;

endmodule

// File: tb/tb_key_scan.sv
// Directed bench for key_scan with SCAN_DIV=4 and DEBOUNCE_CNT=3, so one frame lasts 16 cycles.
// A keyboard model pulls a row low when the matching column is driven
// while that key is held. Frames needed before a load: 3 with
// KEY_SCAN_DEBOUNCE_EN defined, 1 without it.
module tb_key_scan;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row_in = 4'hF;
  logic [3:0]  col_out;
  logic [15:0] keys;
  logic        key_change;

`ifdef KEY_SCAN_DEBOUNCE_EN
  localparam int NF = 3;
  localparam bit DB = 1'b1;
`else
  localparam int NF = 1;
  localparam bit DB = 1'b0;
`endif

  int          cyc;
  int          kc_count;
  int          n_checks;
  int          n_pass;
  logic [15:0] pressed;

  always #5 clock = ~clock;

  key_scan #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clock      (clock),
    .reset      (reset),
    .row_in     (row_in),
    .col_out    (col_out),
    .keys       (keys),
    .key_change (key_change)
  );

  function automatic logic [3:0] kb(input logic [3:0] cols, input logic [15:0] p);
    logic [3:0] r;
    r = 4'hF;
    for (int rr = 0; rr < 4; rr++)
      for (int c = 0; c < 4; c++)
        if (!cols[c] && p[4*rr+c]) r[rr] = 1'b0;
    return r;
  endfunction

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      cyc++;
      if (key_change === 1'b1) kc_count++;
      row_in = kb(col_out, pressed);
    end
  endtask

  task automatic run_to(input int t);
    if (t > cyc) tick(t - cyc);
  endtask

  task automatic set_keys(input logic [15:0] p);
    pressed = p;
    row_in  = kb(col_out, pressed);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset    = 1'b0;
    cyc      = 0;
    kc_count = 0;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    kc_count = 0;
    cyc      = 0;
    pressed  = 16'h0000;

    // Scenario 1: reset state and idle column rotation
    set_keys(16'h0000);
    do_reset();
    check("rst_col_out", {12'h000, col_out}, 16'h000E);
    check("rst_keys", keys, 16'h0000);
    check("rst_key_change", {15'h0000, key_change}, 16'h0000);
    run_to(3);  check("col0_last", {12'h000, col_out}, 16'h000E);
    run_to(4);  check("col1", {12'h000, col_out}, 16'h000D);
    run_to(8);  check("col2", {12'h000, col_out}, 16'h000B);
    run_to(12); check("col3", {12'h000, col_out}, 16'h0007);
    run_to(16); check("col_wrap", {12'h000, col_out}, 16'h000E);
    run_to(80);
    check("idle_keys", keys, 16'h0000);
    check("idle_kc_count", 16'(kc_count), 16'h0000);

    // Scenario 2: hold row1/col1 (bit 5)
    set_keys(16'h0020);
    do_reset();
    run_to(16*NF);     check("s2_before", keys, 16'h0000);
    run_to(16*NF + 1); check("s2_keys", keys, 16'h0020);
    check("s2_kc_pulse", {15'h0000, key_change}, 16'h0001);
    run_to(16*NF + 2); check("s2_kc_clear", {15'h0000, key_change}, 16'h0000);
    run_to(16*NF + 48);
    check("s2_hold", keys, 16'h0020);
    check("s2_kc_count", 16'(kc_count), 16'h0001);

    // Scenario 5: one-cycle reset during column 2, then rescan
    run_to(16*(NF + 4) + 9);
    check("s5_in_col2", {12'h000, col_out}, 16'h000B);
    do_reset();
    check("s5_keys_cleared", keys, 16'h0000);
    check("s5_col_restart", {12'h000, col_out}, 16'h000E);
    check("s5_kc_low", {15'h0000, key_change}, 16'h0000);
    run_to(16*NF);     check("s5_before", keys, 16'h0000);
    run_to(16*NF + 1); check("s5_restored", keys, 16'h0020);

    // Scenario 3: key 5 held for a single frame (frame 2 only)
    set_keys(16'h0000);
    do_reset();
    run_to(16); set_keys(16'h0020);
    run_to(32); set_keys(16'h0000);
    run_to(33); check("s3_glitch", keys, DB ? 16'h0000 : 16'h0020);
    run_to(112);
    check("s3_final", keys, 16'h0000);
    check("s3_kc_count", 16'(kc_count), DB ? 16'h0000 : 16'h0002);

    // Scenario 4: two simultaneous keys, then release both
    set_keys(16'h8001);
    do_reset();
    run_to(16*NF);     check("s4_before", keys, 16'h0000);
    run_to(16*NF + 1); check("s4_keys", keys, 16'h8001);
    check("s4_kc_pulse", {15'h0000, key_change}, 16'h0001);
    run_to(64); set_keys(16'h0000);
    run_to(64 + 16*NF);     check("s4_still_held", keys, 16'h8001);
    run_to(64 + 16*NF + 1); check("s4_released", keys, 16'h0000);
    check("s4_kc_pulse2", {15'h0000, key_change}, 16'h0001);
    run_to(64 + 16*NF + 2); check("s4_kc_clear", {15'h0000, key_change}, 16'h0000);
    check("s4_kc_count", 16'(kc_count), 16'h0002);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/key_scan.md
KEY_SCAN -- requirements
Module: key_scan

Interface
REQ-001 The module SHALL take parameter SCAN_DIV, default 16, the clock cycles each column is driven; legal values are 4 to 65535.
REQ-002 The module SHALL take parameter DEBOUNCE_CNT, default 4, the consecutive identical frames required before `keys` is updated; legal values are 1 to 15.
REQ-003 Port `clock`: input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 Port `reset`: input, 1 bit, synchronous, active-high reset.
REQ-005 Port `row_in`: input, 4 bits, asynchronous matrix row lines, active-low (pulled up; 0 means a pressed key on the driven column).
REQ-006 Port `col_out`: output, 4 bits, matrix column drive, active-low one-hot.
REQ-007 Port `keys`: output, 16 bits, debounced key state, 1 = pressed, bit index 4*row + col, feeding the downstream priority encoder.
REQ-008 Port `key_change`: output, 1 bit, one-cycle pulse when `keys` takes a new value.

Function
REQ-009 `row_in` SHALL pass through a 2-flop synchronizer; all row sampling SHALL use the synchronizer output.
REQ-010 A column counter `col` (0..3) SHALL select the driven column; `col_out` SHALL equal ~(4'b0001 << col).
REQ-011 A divider SHALL count 0..SCAN_DIV-1; on terminal count, `col` SHALL advance by one and wrap from 3 to 0.
REQ-012 On the divider terminal cycle, the inverted synchronized rows SHALL be written into frame bits {4*r + col} for r = 0..3.
REQ-013 The cycle that samples column 3 SHALL complete a frame; the frame value is the 16 bits as updated in that cycle.
REQ-014 On frame completion, a completed frame equal to the previous completed frame SHALL increment a stability counter, saturating at DEBOUNCE_CNT.
REQ-015 On frame completion, a completed frame that differs from the previous completed frame SHALL set the stability counter to 1.
REQ-016 When the stability counter reaches DEBOUNCE_CNT, `keys` SHALL load the frame value in the following cycle.
REQ-017 `key_change` SHALL be 1 in exactly the cycle after `keys` changes value, and 0 otherwise, including when `keys` is reloaded with an equal value.
REQ-018 `keys` SHALL hold its value between updates.
REQ-019 Simultaneous presses SHALL all be reported, with no ghosting suppression.
REQ-020 A frame that changes mid-frame SHALL be treated as a differing frame.

Reset
REQ-021 While `reset` = 1 at a rising edge, the module SHALL set `col` to 0, the divider to 0, the stability counter to 0, the frame and previous-frame registers to 0, the synchronizer flops to 4'b1111, `keys` to 16'h0000 and `key_change` to 0.
REQ-022 Following REQ-021, `col_out` SHALL read 4'b1110 in the cycle after the reset edge.
REQ-023 Reset asserted mid-scan SHALL abandon the partial frame, and scanning SHALL restart from column 0 on the first cycle after `reset` deasserts.

Configuration
REQ-024 With macro KEY_SCAN_DEBOUNCE_EN defined, debouncing SHALL follow REQ-014 to REQ-016.
REQ-025 Without KEY_SCAN_DEBOUNCE_EN, the stability counter SHALL be absent, `keys` SHALL load every completed frame in the following cycle, and DEBOUNCE_CNT SHALL be ignored.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=3, macro defined unless stated; frame = 16 cycles)
REQ-026 Scenario 1: reset, then idle with row_in=4'hF → col_out sequence 1110, 1101, 1011, 0111 with 4 cycles each, repeating; keys stays 16'h0000; key_change stays 0.
REQ-027 Scenario 2: hold key row1/col1 (row_in[1]=0 while col_out=1101) → keys = 16'h0020 one cycle after the third complete frame; a single key_change pulse.
REQ-028 Scenario 3: press key 5 for one frame only, then release → keys remains 16'h0000 and no key_change pulse.
REQ-029 Scenario 4: hold keys row0/col0 and row3/col3 together → keys = 16'h8001; then release both → keys = 16'h0000 after 3 stable frames, with a second key_change pulse.
REQ-030 Scenario 5: assert reset for 1 cycle during column 2 with keys = 16'h0020 → the next cycle shows keys = 16'h0000 and col_out = 1110; the rescan restores 16'h0020 after 3 frames.
REQ-031 Scenario 6: macro undefined, hold key 5 → keys = 16'h0020 one cycle after the first complete frame; release → 16'h0000 after the next frame.
